card_ram_arbiter: RTL and testbench
===================================

Name: card_ram_arbiter

Overview:
- Shares the single external card SRAM (256K x 8, 18-bit address) between two requesters:
  - the CPU-side bank-switch logic (card_ram_rd / card_ram_we / ram_addr);
  - a host loader port used to preload or inspect card RAM.
- Sequences every SRAM access with fixed, programmable strobe timing on mclk28.
- CPU has absolute priority; the host fills idle slots.

Parameters:
- ACCESS_CYCLES, 4, mclk28 cycles per SRAM access (legal range 2..8).
- ADDR_W, 18, SRAM address width.
- DATA_W, 8, SRAM data width.

Ports:
- mclk28  in  1  system clock; one clock domain.
- reset_in  in  1  reset, asynchronous and active-high.
- cpu_strobe  in  1  one-cycle pulse at start of each CPU bus cycle; request inputs are sampled only here.
- cpu_rd  in  1  card_ram_rd from bank logic.
- cpu_we  in  1  card_ram_we from bank logic.
- cpu_addr  in  ADDR_W  ram_addr from bank logic.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data, held until next CPU read completes.
- cpu_done  out  1  one-cycle pulse when a CPU access completes.
- cpu_overrun  out  1  sticky flag: a CPU request was dropped; cleared only by reset.
- host_req  in  1  host request, level; held until host_ack.
- host_we  in  1  host write (1) / read (0).
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DATA_W  host read data, valid with host_ack, held afterwards.
- sram_addr  out  ADDR_W  SRAM address.
- sram_dout  out  DATA_W  SRAM write data.
- sram_din  in  DATA_W  SRAM read data.
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, takes effect immediately, including mid-access):
  - state = IDLE; CPU pending flag cleared.
  - sram_ce_n = sram_oe_n = sram_we_n = 1.
  - sram_addr, sram_dout, cpu_rdata, host_rdata = 0.
  - cpu_done = host_ack = cpu_overrun = busy = 0.
- CPU request capture:
  - On cpu_strobe with cpu_rd|cpu_we, latch addr, data and type (cpu_we wins when both are high) into a pending slot.
  - cpu_strobe with neither rd nor we: no request.
  - cpu_strobe while the pending slot is full: new request dropped, cpu_overrun set. Requests still pending from before are kept.
  - A CPU access in flight does not count as pending; its slot is freed when the access starts.
- FSM states: IDLE, CPU_ACC, HOST_ACC, RECOVER.
  - IDLE -> CPU_ACC if pending (priority, checked first, includes a request captured this same cycle).
  - IDLE -> HOST_ACC if host_req and no pending CPU request.
  - CPU_ACC / HOST_ACC last exactly ACCESS_CYCLES cycles, counted by a cycle counter 0..ACCESS_CYCLES-1, then go to RECOVER.
  - RECOVER lasts 1 cycle with sram_ce_n=1, then returns to IDLE.
- Access timing, counter value k:
  - sram_addr, sram_dout and sram_ce_n=0 are registered at k=0 and stable for the whole access.
  - Read: sram_oe_n=0 for k=0..ACCESS_CYCLES-1. sram_din is captured at k=ACCESS_CYCLES-1 into cpu_rdata or host_rdata.
  - Write: sram_we_n=0 for k=1..ACCESS_CYCLES-2, giving address setup and hold. When ACCESS_CYCLES=2, sram_we_n=0 at k=1 only. sram_oe_n stays 1.
  - cpu_done or host_ack pulses in the first RECOVER cycle.
- Latency:
  - CPU, uncontended, strobe at cycle T: CPU_ACC at T+1, cpu_done at T+1+ACCESS_CYCLES.
  - CPU, worst case (host access just started): cpu_done at T+2*ACCESS_CYCLES+2.
- Host rules:
  - If host_req drops before the access starts, nothing happens.
  - Once started, the access always completes and host_ack pulses.
  - A new host access may start one cycle after ack at the earliest (through IDLE).
- Host starvation is permitted only while CPU requests are continuously pending.

Test Plan:
- Assert reset_in mid-HOST_ACC write at k=1 -> same cycle sram_we_n=1, sram_ce_n=1, busy=0; no host_ack; after release state IDLE, cpu_overrun=0.
- ACCESS_CYCLES=4, cpu_strobe with cpu_we=1, addr 0x2D123, data 0xA5 -> sram_we_n low exactly 2 cycles (k=1,2) at addr 0x2D123 with dout 0xA5; cpu_done 5 cycles after strobe.
- SRAM model preloaded 0x3C at 0x00400, cpu_strobe with cpu_rd=1 -> sram_oe_n low 4 cycles; cpu_rdata=0x3C when cpu_done pulses.
- host_req read at 0x10000 and cpu_strobe with cpu_rd in the same cycle -> CPU access served first; host access starts the cycle after CPU RECOVER; host_ack follows, host_rdata = preloaded value.
- HOST_ACC in progress, two cpu_strobe reads 2 cycles apart -> first request kept pending and served next; second dropped; cpu_overrun=1 and stays 1 until reset.
- cpu_strobe with cpu_rd=cpu_we=1 -> write cycle performed (sram_we_n pulses, sram_oe_n stays 1).

Source files
------------

// File: rtl/card_ram_arbiter.sv
// Arbitrates the single card SRAM between the CPU bank logic (absolute priority)
// and a host loader port, sequencing every access with fixed strobe timing.
module card_ram_arbiter #(
    parameter int ACCESS_CYCLES = 4,
    parameter int ADDR_W        = 18,
    parameter int DATA_W        = 8
) (
    input  logic              mclk28,
    input  logic              reset_in,
    input  logic              cpu_strobe,
    input  logic              cpu_rd,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_overrun,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_ACC  = 2'd1,
        HOST_ACC = 2'd2,
        RECOVER  = 2'd3
    } state_t;

    localparam logic [3:0] K_LAST  = 4'(ACCESS_CYCLES - 1);
    // Write strobe spans k=1..ACCESS_CYCLES-2, collapsing to k=1 alone for 2-cycle accesses.
    localparam logic [3:0] WE_LAST = (ACCESS_CYCLES == 2) ? 4'd1 : 4'(ACCESS_CYCLES - 2);

    state_t            r_state;
    logic [3:0]        r_k;
    logic              r_acc_we;
    logic              r_pend;
    logic              r_pend_we;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [DATA_W-1:0] r_pend_wdata;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_sram_dout;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_host_rdata;
    logic              r_cpu_done;
    logic              r_host_ack;
    logic              r_overrun;

    logic              w_cpu_req;
    logic [3:0]        w_k_next;

    assign w_cpu_req = cpu_strobe & (cpu_rd | cpu_we);
    assign w_k_next  = r_k + 4'd1;

    always_ff @(posedge mclk28 or posedge reset_in) begin
        if (reset_in) begin
            r_state      <= IDLE;
            r_k          <= '0;
            r_acc_we     <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_we    <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_wdata <= '0;
            r_sram_addr  <= '0;
            r_sram_dout  <= '0;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
            r_cpu_done   <= 1'b0;
            r_host_ack   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_cpu_done <= 1'b0;
            r_host_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_pend || w_cpu_req) begin
                        r_state <= CPU_ACC;
                        r_k     <= '0;
                        r_pend  <= 1'b0;
                        r_ce_n  <= 1'b0;
                        r_we_n  <= 1'b1;
                        if (r_pend) begin
                            // The older pending request wins; a strobe landing now finds the slot full.
                            r_acc_we    <= r_pend_we;
                            r_sram_addr <= r_pend_addr;
                            r_sram_dout <= r_pend_wdata;
                            r_oe_n      <= r_pend_we;
                            if (w_cpu_req) r_overrun <= 1'b1;
                        end else begin
                            r_acc_we    <= cpu_we;
                            r_sram_addr <= cpu_addr;
                            r_sram_dout <= cpu_wdata;
                            r_oe_n      <= cpu_we;
                        end
                    end else if (host_req) begin
                        r_state     <= HOST_ACC;
                        r_k         <= '0;
                        r_acc_we    <= host_we;
                        r_sram_addr <= host_addr;
                        r_sram_dout <= host_wdata;
                        r_ce_n      <= 1'b0;
                        r_oe_n      <= host_we;
                        r_we_n      <= 1'b1;
                    end
                end
                CPU_ACC, HOST_ACC: begin
                    if (r_k == K_LAST) begin
                        r_state <= RECOVER;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        if (r_state == CPU_ACC) begin
                            r_cpu_done <= 1'b1;
                            if (!r_acc_we) r_cpu_rdata <= sram_din;
                        end else begin
                            r_host_ack <= 1'b1;
                            if (!r_acc_we) r_host_rdata <= sram_din;
                        end
                    end else begin
                        r_k    <= w_k_next;
                        r_we_n <= ~(r_acc_we && (w_k_next <= WE_LAST));
                    end
                end
                RECOVER: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            if ((r_state != IDLE) && w_cpu_req) begin
                if (r_pend) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pend       <= 1'b1;
                    r_pend_we    <= cpu_we;
                    r_pend_addr  <= cpu_addr;
                    r_pend_wdata <= cpu_wdata;
                end
            end
        end
    end

    assign sram_addr   = r_sram_addr;
    assign sram_dout   = r_sram_dout;
    assign sram_ce_n   = r_ce_n;
    assign sram_oe_n   = r_oe_n;
    assign sram_we_n   = r_we_n;
    assign cpu_rdata   = r_cpu_rdata;
    assign host_rdata  = r_host_rdata;
    assign cpu_done    = r_cpu_done;
    assign host_ack    = r_host_ack;
    assign cpu_overrun = r_overrun;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_card_ram_arbiter.sv
// Bench for card_ram_arbiter: SRAM array model, transaction-level reference
// schedule checked every cycle, plus directed literal scenarios.
module tb_card_ram_arbiter;
    localparam int AC      = 4;
    localparam int WE_LAST = (AC == 2) ? 1 : AC - 2;

    logic        mclk28, reset_in;
    logic        cpu_strobe, cpu_rd, cpu_we;
    logic [17:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_done, cpu_overrun;
    logic        host_req, host_we;
    logic [17:0] host_addr;
    logic [7:0]  host_wdata, host_rdata;
    logic        host_ack;
    logic [17:0] sram_addr;
    logic [7:0]  sram_dout, sram_din;
    logic        sram_ce_n, sram_oe_n, sram_we_n, busy;

    card_ram_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(18), .DATA_W(8)) dut (
        .mclk28(mclk28), .reset_in(reset_in),
        .cpu_strobe(cpu_strobe), .cpu_rd(cpu_rd), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_done(cpu_done), .cpu_overrun(cpu_overrun),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .busy(busy)
    );

    // ---------------- clock / SRAM device ----------------
    initial begin
        mclk28 = 1'b0;
        forever #5 mclk28 = ~mclk28;
    end

    logic [7:0] sram_mem [0:262143];
    logic [7:0] ref_mem  [0:262143];
    assign sram_din = sram_mem[sram_addr];

    initial begin
        forever begin
            @(negedge mclk28);
            if (!reset_in && !sram_ce_n && !sram_we_n) sram_mem[sram_addr] = sram_dout;
        end
    end

    // ---------------- scoreboard bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference schedule ----------------
    // One record per SRAM access: its start cycle plus payload; output shape follows from (cycle - start).
    int          cyc = 0;
    int          p;
    bit          req, idle;
    bit          a_v = 0, a_cpu, a_we;
    int          a_start = 0;
    logic [17:0] a_addr;
    logic [7:0]  a_data;
    bit          p_v = 0, p_we;
    logic [17:0] p_addr;
    logic [7:0]  p_data;
    bit          m_ovr = 0;
    logic [7:0]  m_cpu_rd = 0, m_host_rd = 0;

    initial begin
        forever begin
            @(posedge mclk28 or posedge reset_in);
            if (reset_in) begin
                a_v = 0; p_v = 0; m_ovr = 0; m_cpu_rd = 0; m_host_rd = 0;
            end else begin
                p = cyc;
                if (a_v && p == a_start + AC - 1) begin
                    if (a_we) ref_mem[a_addr] = a_data;
                    else if (a_cpu) m_cpu_rd = ref_mem[a_addr];
                    else m_host_rd = ref_mem[a_addr];
                end
                req  = cpu_strobe && (cpu_rd || cpu_we);
                idle = !a_v || (p >= a_start + AC + 1);
                if (idle) begin
                    if (p_v || req) begin
                        a_v = 1; a_start = p + 1; a_cpu = 1;
                        if (p_v) begin
                            a_we = p_we; a_addr = p_addr; a_data = p_data;
                            if (req) m_ovr = 1;
                        end else begin
                            a_we = cpu_we; a_addr = cpu_addr; a_data = cpu_wdata;
                        end
                        p_v = 0;
                    end else if (host_req) begin
                        a_v = 1; a_start = p + 1; a_cpu = 0;
                        a_we = host_we; a_addr = host_addr; a_data = host_wdata;
                    end
                end else if (req) begin
                    if (p_v) m_ovr = 1;
                    else begin
                        p_v = 1; p_we = cpu_we; p_addr = cpu_addr; p_data = cpu_wdata;
                    end
                end
                cyc = p + 1;
            end
        end
    end

    int  k;
    bit  in_acc, in_rec;
    initial begin
        forever begin
            @(negedge mclk28);
            if (!reset_in) begin
                k      = cyc - a_start;
                in_acc = a_v && (k >= 0) && (k < AC);
                in_rec = a_v && (k == AC);
                chk("busy",      busy,      in_acc || in_rec);
                chk("ce_n",      sram_ce_n, !in_acc);
                chk("oe_n",      sram_oe_n, !(in_acc && !a_we));
                chk("we_n",      sram_we_n, !(in_acc && a_we && k >= 1 && k <= WE_LAST));
                chk("cpu_done",  cpu_done,  in_rec && a_cpu);
                chk("host_ack",  host_ack,  in_rec && !a_cpu);
                chk("overrun",   cpu_overrun, m_ovr);
                chk("cpu_rdata", cpu_rdata, m_cpu_rd);
                chk("host_rdata", host_rdata, m_host_rd);
                if (in_acc) chk("sram_addr", sram_addr, a_addr);
                if (in_acc && a_we) chk("sram_dout", sram_dout, a_data);
            end
        end
    end

    // ---------------- driver tasks ----------------
    int          o_done_first, o_done_cnt, o_ack_first, o_ack_cnt;
    int          o_we_lo, o_we_first, o_oe_lo, o_oe_first;
    logic [17:0] o_addr_we, o_addr_oe;
    logic [7:0]  o_dout_we;

    // Steps n cycles recording strobe shape; may inject CPU read strobes at indices sa/sb.
    task automatic observe(input int n, input int sa, input int sb,
                           input logic [17:0] aa, input logic [17:0] ab);
        o_done_first = 0; o_done_cnt = 0; o_ack_first = 0; o_ack_cnt = 0;
        o_we_lo = 0; o_we_first = 0; o_oe_lo = 0; o_oe_first = 0;
        o_addr_we = 0; o_addr_oe = 0; o_dout_we = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge mclk28);
            if (cpu_done) begin o_done_cnt++; if (o_done_first == 0) o_done_first = i; end
            if (host_ack) begin o_ack_cnt++;  if (o_ack_first == 0)  o_ack_first  = i; end
            if (!sram_we_n) begin
                o_we_lo++;
                if (o_we_first == 0) begin o_we_first = i; o_addr_we = sram_addr; o_dout_we = sram_dout; end
            end
            if (!sram_oe_n) begin
                o_oe_lo++;
                if (o_oe_first == 0) begin o_oe_first = i; o_addr_oe = sram_addr; end
            end
            if (host_ack) host_req = 1'b0;
            cpu_strobe = (i == sa) || (i == sb);
            cpu_rd     = 1'b1;
            cpu_we     = 1'b0;
            cpu_addr   = (i == sa) ? aa : ab;
        end
    endtask

    task automatic cpu_strobe_now(input logic rd, input logic we, input logic [17:0] a, input logic [7:0] d);
        cpu_rd = rd; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_strobe = 1'b1;
    endtask

    function automatic logic [17:0] pick_addr();
        int r;
        r = $urandom_range(31, 0);
        return (r < 16) ? (18'h00400 + 18'(r)) : (18'h3FFE0 + 18'(r));
    endfunction

    task automatic cpu_drv(input int n, input int gmin, input int gmax);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gmax, gmin)) @(negedge mclk28);
            cpu_strobe_now(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), pick_addr(), 8'($urandom));
            @(negedge mclk28);
            cpu_strobe = 1'b0;
        end
    endtask

    task automatic host_drv(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(6, 0)) @(negedge mclk28);
            host_we = 1'($urandom_range(1, 0)); host_addr = pick_addr(); host_wdata = 8'($urandom);
            host_req = 1'b1;
            if ($urandom_range(7, 0) == 0) begin
                @(negedge mclk28);
                host_req = 1'b0;
                repeat (2 * AC + 4) @(negedge mclk28);
            end else begin
                t = 0;
                do begin @(negedge mclk28); t++; end while (!host_ack && t < 3000);
                chk("host_ack_wait", host_ack, 1'b1);
                host_req = 1'b0;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_in = 1'b1;
        cpu_strobe = 0; cpu_rd = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        for (int a = 0; a < 262144; a++) begin
            sram_mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'(a >> 16);
            ref_mem[a]  = sram_mem[a];
        end
        sram_mem[18'h00400] = 8'h3C; ref_mem[18'h00400] = 8'h3C;
        sram_mem[18'h10000] = 8'h77; ref_mem[18'h10000] = 8'h77;

        repeat (3) @(negedge mclk28);
        chk("rst_ce_n", sram_ce_n, 1'b1);
        chk("rst_oe_n", sram_oe_n, 1'b1);
        chk("rst_we_n", sram_we_n, 1'b1);
        chk("rst_addr", sram_addr, 18'h0);
        chk("rst_dout", sram_dout, 8'h0);
        chk("rst_rdata", {cpu_rdata, host_rdata}, 16'h0);
        chk("rst_flags", {cpu_done, host_ack, cpu_overrun, busy}, 4'b0000);
        reset_in = 1'b0;
        repeat (2) @(negedge mclk28);

        // CPU write, uncontended
        cpu_strobe_now(1'b0, 1'b1, 18'h2D123, 8'hA5);
        observe(12, 0, 0, 18'h0, 18'h0);
        chk("wr_done_lat", o_done_first, 5);
        chk("wr_done_cnt", o_done_cnt, 1);
        chk("wr_we_len",   o_we_lo, 2);
        chk("wr_we_first", o_we_first, 2);
        chk("wr_addr",     o_addr_we, 18'h2D123);
        chk("wr_dout",     o_dout_we, 8'hA5);
        chk("wr_oe_len",   o_oe_lo, 0);

        // CPU read of preloaded byte
        cpu_strobe_now(1'b1, 1'b0, 18'h00400, 8'h00);
        observe(10, 0, 0, 18'h0, 18'h0);
        chk("rd_oe_len",   o_oe_lo, 4);
        chk("rd_oe_first", o_oe_first, 1);
        chk("rd_done_lat", o_done_first, 5);
        chk("rd_rdata",    cpu_rdata, 8'h3C);
        chk("model_cpu_rd", m_cpu_rd, 8'h3C);

        // Simultaneous host read and CPU read: CPU first
        host_we = 1'b0; host_addr = 18'h10000; host_req = 1'b1;
        cpu_strobe_now(1'b1, 1'b0, 18'h00400, 8'h00);
        observe(16, 0, 0, 18'h0, 18'h0);
        chk("arb_done_lat", o_done_first, 5);
        chk("arb_ack_lat",  o_ack_first, 11);
        chk("arb_oe_len",   o_oe_lo, 8);
        chk("arb_hrdata",   host_rdata, 8'h77);
        chk("model_host_rd", m_host_rd, 8'h77);

        // rd and we both high: write wins
        cpu_strobe_now(1'b1, 1'b1, 18'h00555, 8'h5A);
        observe(10, 0, 0, 18'h0, 18'h0);
        chk("both_we_len", o_we_lo, 2);
        chk("both_oe_len", o_oe_lo, 0);
        chk("both_done",   o_done_first, 5);
        cpu_strobe_now(1'b1, 1'b0, 18'h00555, 8'h00);
        observe(10, 0, 0, 18'h0, 18'h0);
        chk("both_readback", cpu_rdata, 8'h5A);

        // Host write in progress, two CPU reads 2 cycles apart
        host_we = 1'b1; host_addr = 18'h00800; host_wdata = 8'h11; host_req = 1'b1;
        observe(20, 1, 3, 18'h00400, 18'h00555);
        chk("ovr_ack_lat",  o_ack_first, 5);
        chk("ovr_oe_first", o_oe_first, 7);
        chk("ovr_addr",     o_addr_oe, 18'h00400);
        chk("ovr_done_lat", o_done_first, 11);
        chk("ovr_done_cnt", o_done_cnt, 1);
        chk("ovr_flag",     cpu_overrun, 1'b1);
        chk("ovr_rdata",    cpu_rdata, 8'h3C);
        observe(5, 0, 0, 18'h0, 18'h0);
        chk("ovr_sticky",   cpu_overrun, 1'b1);

        // Reset mid host write at k=1
        host_we = 1'b1; host_addr = 18'h00900; host_wdata = 8'h22; host_req = 1'b1;
        @(negedge mclk28);
        @(negedge mclk28);
        chk("mid_we_low", sram_we_n, 1'b0);
        reset_in = 1'b1;
        host_req = 1'b0;
        #1;
        chk("mid_rst_we_n", sram_we_n, 1'b1);
        chk("mid_rst_ce_n", sram_ce_n, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ovr",  cpu_overrun, 1'b0);
        repeat (2) @(negedge mclk28);
        reset_in = 1'b0;
        observe(10, 0, 0, 18'h0, 18'h0);
        chk("mid_no_ack", o_ack_cnt, 0);
        chk("mid_idle",   busy, 1'b0);
        chk("mid_ovr",    cpu_overrun, 1'b0);

        // Randomized traffic: sparse then dense CPU load against host
        fork
            cpu_drv(60, 4, 14);
            host_drv(40);
        join
        fork
            cpu_drv(100, 2, 8);
            host_drv(40);
        join
        repeat (40) @(negedge mclk28);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
